// File: rtl/game_pkg.sv
// Shared definitions for the artillery game blocks: key codes, turn states and
// the aim/power limits shared by fire_control, the bomb block and the tank block.
package game_pkg;

    localparam logic [7:0] KEY_NONE  = 8'h00;
    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_SPACE = 8'h2C;

    localparam logic [3:0] ANGLE_MAX     = 4'd8;
    localparam logic [3:0] ANGLE_P1_INIT = 4'd6;
    localparam logic [3:0] ANGLE_P2_INIT = 4'd2;
    localparam logic [2:0] POWER_MAX     = 3'd7;

    typedef enum logic [2:0] {
        ST_AIM,
        ST_CHARGE,
        ST_LAUNCH,
        ST_FLIGHT,
        ST_SETTLE
    } state_t;

endpackage

// File: rtl/key_edge.sv
// Turns the level-style HID keycode into one-cycle press events, so a held key
// produces exactly one event and switching directly between codes produces a new one.
module key_edge
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keycode,
    output logic       left_ev,
    output logic       right_ev,
    output logic       space_ev
);

    logic [7:0] prev_key;
    logic       key_new;

    // NOTE: registers are written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) prev_key <= KEY_NONE;
        else       prev_key <= keycode;
    end

    assign key_new  = (keycode != prev_key);
    assign left_ev  = key_new && (keycode == KEY_LEFT);
    assign right_ev = key_new && (keycode == KEY_RIGHT);
    assign space_ev = key_new && (keycode == KEY_SPACE);

endmodule

// File: rtl/fire_control.sv
// Turn sequencer for the two-player artillery game: aiming, power charging,
// launch handshake with the bomb block, flight supervision and the settle pause.
module fire_control
    import game_pkg::*;
#(
    parameter int CHARGE_FRAMES  = 8,
    parameter int SETTLE_FRAMES  = 30,
    parameter int FLIGHT_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic [9:0] p1X,
    input  logic [9:0] p1Y,
    input  logic [9:0] p2X,
    input  logic [9:0] p2Y,
    input  logic       bomb_done,
    output logic       launch,
    output logic [9:0] launchX,
    output logic [9:0] launchY,
    output logic [3:0] angle,
    output logic [2:0] power,
    output logic       player,
    output logic       busy
);

    localparam int CW = $clog2(CHARGE_FRAMES + 1);
    localparam int FMAX = (FLIGHT_TIMEOUT > SETTLE_FRAMES) ? FLIGHT_TIMEOUT : SETTLE_FRAMES;
    localparam int FW = $clog2(FMAX + 1);

    logic left_ev, right_ev, space_ev;

    key_edge u_key_edge (
        .clk      (clk),
        .reset    (reset),
        .keycode  (keycode),
        .left_ev  (left_ev),
        .right_ev (right_ev),
        .space_ev (space_ev)
    );

    state_t        state_q, state_n;
    logic          player_q, player_n;
    logic [3:0]    angle_p1_q, angle_p1_n, angle_p2_q, angle_p2_n;
    logic [3:0]    angle_act, angle_new;
    logic [2:0]    power_q, power_n;
    logic [CW-1:0] tick_q, tick_n;
    logic [FW-1:0] frame_q, frame_n;
    logic          armed_q, armed_n;
    logic [9:0]    launch_x_q, launch_x_n, launch_y_q, launch_y_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_AIM;
            player_q   <= 1'b0;
            angle_p1_q <= ANGLE_P1_INIT;
            angle_p2_q <= ANGLE_P2_INIT;
            power_q    <= '0;
            tick_q     <= '0;
            frame_q    <= '0;
            armed_q    <= 1'b0;
            launch_x_q <= '0;
            launch_y_q <= '0;
        end else begin
            state_q    <= state_n;
            player_q   <= player_n;
            angle_p1_q <= angle_p1_n;
            angle_p2_q <= angle_p2_n;
            power_q    <= power_n;
            tick_q     <= tick_n;
            frame_q    <= frame_n;
            armed_q    <= armed_n;
            launch_x_q <= launch_x_n;
            launch_y_q <= launch_y_n;
        end
    end

    assign angle_act = player_q ? angle_p2_q : angle_p1_q;

    // NOTE: every signal assigned below gets a default first, so no path can infer a latch.
    always_comb begin
        state_n    = state_q;
        player_n   = player_q;
        angle_p1_n = angle_p1_q;
        angle_p2_n = angle_p2_q;
        angle_new  = angle_act;
        power_n    = power_q;
        tick_n     = tick_q;
        frame_n    = frame_q;
        armed_n    = armed_q;
        launch_x_n = launch_x_q;
        launch_y_n = launch_y_q;

        unique case (state_q)
            ST_AIM: begin
                if (space_ev) begin
                    power_n = '0;
                    tick_n  = '0;
                    state_n = ST_CHARGE;
                end else if (left_ev && angle_act != 4'd0) begin
                    angle_new = angle_act - 4'd1;
                end else if (right_ev && angle_act != ANGLE_MAX) begin
                    angle_new = angle_act + 4'd1;
                end
                if (player_q) angle_p2_n = angle_new;
                else          angle_p1_n = angle_new;
            end

            ST_CHARGE: begin
                // Any code other than SPACE, including a new arrow, counts as release.
                if (keycode != KEY_SPACE) begin
                    launch_x_n = player_q ? p2X : p1X;
                    launch_y_n = player_q ? p2Y : p1Y;
                    state_n    = ST_LAUNCH;
                end else if (frame_tick) begin
                    if (tick_q == CW'(CHARGE_FRAMES - 1)) begin
                        tick_n = '0;
                        if (power_q != POWER_MAX) power_n = power_q + 3'd1;
                    end else begin
                        tick_n = tick_q + CW'(1);
                    end
                end
            end

            ST_LAUNCH: begin
                if (frame_tick) begin
                    frame_n = '0;
                    armed_n = 1'b0;
                    state_n = ST_FLIGHT;
                end
            end

            ST_FLIGHT: begin
                if ((armed_q && bomb_done) ||
                    (frame_tick && frame_q == FW'(FLIGHT_TIMEOUT - 1))) begin
                    frame_n = '0;
                    state_n = ST_SETTLE;
                end else begin
                    if (!bomb_done) armed_n = 1'b1;
                    if (frame_tick) frame_n = frame_q + FW'(1);
                end
            end

            ST_SETTLE: begin
                if (frame_tick) begin
                    if (frame_q == FW'(SETTLE_FRAMES - 1)) begin
                        frame_n  = '0;
                        player_n = ~player_q;
                        state_n  = ST_AIM;
                    end else begin
                        frame_n = frame_q + FW'(1);
                    end
                end
            end

            default: state_n = ST_AIM;
        endcase
    end

    assign launch  = (state_q == ST_LAUNCH);
    assign busy    = (state_q != ST_AIM);
    assign launchX = launch_x_q;
    assign launchY = launch_y_q;
    assign angle   = angle_act;
    assign power   = power_q;
    assign player  = player_q;

endmodule
